uart_rx_fifo: RTL

- Receive-side buffer between the UART core and the CPU bus decode.
- Drains bytes from the UART (rx_data/valid/rd handshake) into a synchronous FIFO, so back-to-back characters are not lost while software is busy.
- The CPU side pops bytes and reads occupancy/status through the existing peripheral read path at 0x20002000/0x20002004.

---
 rtl/uart_rx_fifo.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART core and the CPU
// read path. A three-state ingest FSM drains one byte per UART handshake into
// a DEPTH-entry synchronous FIFO. The CPU pops from the head.
//
// Optional build macro RX_FIFO_OVERFLOW_EN:
//   A byte arriving while the FIFO is full is dropped, but the UART is still
//   acknowledged so that it is freed. The drop also sets a sticky overflow_o
//   flag, which clr_ovf_i clears.
//   Without the macro, the byte stays in the UART until space frees up, and
//   overflow_o is tied low.
module uart_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic [7:0]    uart_rx_data_i,
    input  logic          uart_valid_i,
    output logic          uart_rd_o,
    input  logic          pop_i,
    output logic [7:0]    data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o,
    output logic          overflow_o,
    input  logic          clr_ovf_i
);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_nxt;
    logic          wr_en, pop_en, drop, take;

    // Accept only from IDLE, using pre-pop fullness.
    // ACK/HOLD enforce the 3-cycle spacing, so a level-high valid is
    // never counted twice.
    assign wr_en  = (state == IDLE) && uart_valid_i && !full_o;
    assign pop_en = pop_i && !empty_o;
    assign take   = wr_en || drop;

`ifdef RX_FIFO_OVERFLOW_EN
    logic ovf;

    assign drop       = (state == IDLE) && uart_valid_i && full_o;
    assign overflow_o = ovf;

    // Sticky overflow: set wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i)        ovf <= 1'b0;
        else if (drop)      ovf <= 1'b1;
        else if (clr_ovf_i) ovf <= 1'b0;
    end
`else
    logic unused_clr;

    assign drop       = 1'b0;
    assign overflow_o = 1'b0;
    assign unused_clr = clr_ovf_i;
`endif

    // Ingest FSM state register.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nxt;
    end

    // Ingest FSM next state: IDLE -> ACK -> HOLD -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = ACK;
            ACK:     state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ingest FSM outputs: the read pulse is exactly the ACK cycle.
    // Because it is derived from state, reset drops it at once.
    always_comb begin
        uart_rd_o = (state == ACK);
    end

    // Storage is not reset; contents are only meaningful below count_o.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= uart_rx_data_i;
    end

    assign data_o = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
            if (pop_en) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Next occupancy: a simultaneous write and pop leaves it unchanged.
    always_comb begin
        count_nxt = count_o;
        case ({wr_en, pop_en})
            2'b10:   count_nxt = count_o + (AW+1)'(1);
            2'b01:   count_nxt = count_o - (AW+1)'(1);
            default: count_nxt = count_o;
        endcase
    end

    // Occupancy and flags are registered together so they always agree.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            count_o <= '0;
            empty_o <= 1'b1;
            full_o  <= 1'b0;
        end else begin
            count_o <= count_nxt;
            empty_o <= (count_nxt == '0);
            full_o  <= (count_nxt == DEPTH[AW:0]);
        end
    end

endmodule
